// File: rtl/C.sv
// Shared decode-side types: functional-unit codes and the decoded dynamic instruction.
package C;

  typedef enum logic [3:0] {
    FU_NONE = 4'd0,
    FU_BRU  = 4'd1,
    FU_CSR  = 4'd2,
    FU_ALU  = 4'd3,
    FU_MUL  = 4'd4,
    FU_DIV  = 4'd5,
    FU_LSU  = 4'd6,
    FU_AMO  = 4'd7,
    FU_FPU  = 4'd8
  } fu_t;

  typedef struct packed {
    logic        valid;
    fu_t         fu;
    logic [7:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } si_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        fault;
    logic [3:0]  cause;
    si_t         si;
  } di_t;

endpackage

// File: rtl/dispatch_buffer.sv
// In-order dispatch FIFO between decode and the FU issue ports; head routed by si.fu.
// Optional zero-latency empty-buffer bypass enabled by defining DISPATCH_BYPASS_EN.
module dispatch_buffer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned NB_FU   = 9,
  parameter int unsigned STALL_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  C::di_t                   in_di_i,
  output logic [NB_FU-1:0]         out_valid_o,
  input  logic [NB_FU-1:0]         out_ready_i,
  output C::di_t                   out_di_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [STALL_W-1:0]       stall_cnt_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  C::di_t           mem [DEPTH];

  logic             empty, full;
  logic             byp;
  logic             has_head;
  C::di_t           head_di;
  logic [3:0]       route;
  logic             accepted, pop, byp_take, push;
  logic [STALL_W-1:0] stall_q;

  function automatic logic [3:0] route_of(input C::di_t d);
    if (d.fault || !d.si.valid || (32'(d.si.fu) >= NB_FU))
      return 4'(C::FU_NONE);
    return 4'(d.si.fu);
  endfunction

  assign empty = (rd_ptr == wr_ptr);
  assign full  = (rd_ptr[IDX_W-1:0] == wr_ptr[IDX_W-1:0]) &&
                 (rd_ptr[IDX_W] != wr_ptr[IDX_W]);

`ifdef DISPATCH_BYPASS_EN
  assign byp = empty && !flush_i && in_valid_i;
`else
  assign byp = 1'b0;
`endif

  // Empty buffer shows all-zero payload unless the bypass is presenting decode directly.
  always_comb begin
    head_di  = '0;
    has_head = 1'b0;
    if (!empty) begin
      head_di  = mem[rd_ptr[IDX_W-1:0]];
      has_head = 1'b1;
    end else if (byp) begin
      head_di  = in_di_i;
      has_head = 1'b1;
    end
  end

  assign route    = route_of(head_di);
  assign out_di_o = head_di;

  always_comb begin
    out_valid_o = '0;
    if (has_head && !flush_i) begin
      for (int unsigned i = 0; i < NB_FU; i++)
        out_valid_o[i] = (32'(route) == i);
    end
  end

  assign accepted   = |(out_valid_o & out_ready_i);
  assign pop        = accepted && !empty;
  assign byp_take   = accepted && empty;
  assign in_ready_o = !full && !flush_i;
  assign push       = in_valid_i && in_ready_o && !byp_take;
  assign count_o    = wr_ptr - rd_ptr;
  assign stall_cnt_o = stall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      stall_q <= '0;
    end else if (flush_i) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      stall_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (empty || !(|out_valid_o) || accepted)
        stall_q <= '0;
      else if (stall_q != '1)
        stall_q <= stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[IDX_W-1:0]] <= in_di_i;
  end

endmodule

// File: tb/tb_dispatch_buffer.sv
// Scoreboard bench for dispatch_buffer: directed scenarios plus a random stream.
module tb_dispatch_buffer;

`ifdef DISPATCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  C::di_t      in_di = '0;
  logic [8:0]  out_valid;
  logic [8:0]  out_ready = '0;
  C::di_t      out_di;
  logic [2:0]  count;
  logic [15:0] stall;

  int tests = 0;
  int fails = 0;

  C::di_t      model_q[$];
  logic [15:0] m_stall = '0;

  dispatch_buffer #(.DEPTH(4), .NB_FU(9), .STALL_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_di_i(in_di),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_di_o(out_di),
    .count_o(count), .stall_cnt_o(stall)
  );

  always #5 clk = ~clk;

  function automatic int tb_route(input C::di_t d);
    if (d.fault) return 0;
    if (!d.si.valid) return 0;
    if (int'(d.si.fu) > 8) return 0;
    return int'(d.si.fu);
  endfunction

  function automatic C::di_t mk(input logic [3:0] fu, input logic fault, input logic sval);
    C::di_t d;
    d = '0;
    d.pc       = $urandom;
    d.fault    = fault;
    d.cause    = 4'($urandom);
    d.si.valid = sval;
    d.si.fu    = C::fu_t'(fu);
    d.si.op    = 8'($urandom);
    d.si.rd    = 5'($urandom);
    d.si.imm   = $urandom;
    return d;
  endfunction

  task automatic drive(input logic v, input C::di_t d, input logic [8:0] r, input logic f);
    @(negedge clk);
    in_valid  = v;
    in_di     = d;
    out_ready = r;
    flush     = f;
    #1;
  endtask

  task automatic idle(input logic [8:0] r);
    drive(1'b0, '0, r, 1'b0);
  endtask

  // Scoreboard monitor: mid-cycle, predicts outputs from the reference queue, then advances it.
  C::di_t     mon_head;
  bit         mon_has, mon_byp, mon_pop, mon_push, mon_rdy;
  logic [8:0] mon_v;
  always begin
    @(negedge clk);
    #3;
    if (!rst_n) begin
      model_q.delete();
      m_stall = '0;
    end else begin
      mon_byp  = BYP && (model_q.size() == 0) && in_valid && !flush;
      mon_has  = (model_q.size() != 0) || mon_byp;
      mon_head = (model_q.size() != 0) ? model_q[0] : in_di;
      mon_rdy  = (model_q.size() < 4) && !flush;
      mon_v    = '0;
      if (mon_has && !flush) mon_v[tb_route(mon_head)] = 1'b1;
      tests++;
      if (out_valid !== mon_v) begin
        fails++; $display("FAIL sb_valid: got %b expected %b", out_valid, mon_v);
      end
      if (mon_has && !flush) begin
        tests++;
        if (out_di !== mon_head) begin
          fails++; $display("FAIL sb_payload: got %h expected %h", out_di, mon_head);
        end
      end
      tests++;
      if (count !== 3'(model_q.size())) begin
        fails++; $display("FAIL sb_count: got %0d expected %0d", count, model_q.size());
      end
      tests++;
      if (stall !== m_stall) begin
        fails++; $display("FAIL sb_stall: got %0d expected %0d", stall, m_stall);
      end
      tests++;
      if (in_ready !== mon_rdy) begin
        fails++; $display("FAIL sb_in_ready: got %b expected %b", in_ready, mon_rdy);
      end
      mon_pop = (mon_v & out_ready) != 9'b0;
      if (flush) begin
        model_q.delete();
        m_stall = '0;
      end else begin
        if (model_q.size() == 0 || mon_v == 9'b0 || mon_pop) m_stall = '0;
        else if (m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
        mon_push = in_valid && mon_rdy && !(mon_pop && mon_byp);
        if (mon_pop && !mon_byp) void'(model_q.pop_front());
        if (mon_push) model_q.push_back(in_di);
      end
    end
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if (count !== 3'd0 || stall !== 16'd0 || out_valid !== 9'd0 || in_ready !== 1'b1 || out_di !== C::di_t'('0)) begin
      fails++;
      $display("FAIL reset: count=%0d stall=%0d valid=%b ready=%b di=%h expected 0/0/0/1/0",
               count, stall, out_valid, in_ready, out_di);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_alu();
    drive(1'b1, mk(4'd3, 1'b0, 1'b1), 9'h1FF, 1'b0);
    tests++;
    if (out_valid !== (BYP ? 9'b000001000 : 9'b0)) begin
      fails++; $display("FAIL alu_first_cycle: got %b", out_valid);
    end
    idle(9'h1FF);
    tests++;
    if (out_valid !== (BYP ? 9'b0 : 9'b000001000) || count !== (BYP ? 3'd0 : 3'd1)) begin
      fails++; $display("FAIL alu_offer: valid=%b count=%0d", out_valid, count);
    end
    idle(9'h1FF);
    tests++;
    if (count !== 3'd0) begin
      fails++; $display("FAIL alu_popped: got count %0d expected 0", count);
    end
  endtask

  task automatic test_fill_stall();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, mk(4'd5, 1'b0, 1'b1), 9'h0, 1'b0);
      tests++;
      if (stall !== 16'((i == 0) ? 0 : i - 1)) begin
        fails++; $display("FAIL fill_stall_%0d: got %0d expected %0d", i, stall, (i == 0) ? 0 : i - 1);
      end
    end
    tests++;
    if (in_ready !== 1'b0 || count !== 3'd4) begin
      fails++; $display("FAIL fill_full: ready=%b count=%0d expected 0/4", in_ready, count);
    end
    idle(9'h0);
    tests++;
    if (stall !== 16'd4) begin
      fails++; $display("FAIL stall_incr: got %0d expected 4", stall);
    end
    repeat (5) idle(9'h1FF);
  endtask

  task automatic test_routing_fault();
    drive(1'b1, mk(4'd6, 1'b1, 1'b1), 9'h0, 1'b0);
    drive(1'b1, mk(4'd12, 1'b0, 1'b1), 9'h0, 1'b0);
    drive(1'b1, mk(4'd3, 1'b0, 1'b0), 9'h0, 1'b0);
    idle(9'h0);
    tests++;
    if (out_valid !== 9'b000000001) begin
      fails++; $display("FAIL route_fault: got %b expected 000000001", out_valid);
    end
    idle(9'h001);
    idle(9'h0);
    tests++;
    if (out_valid !== 9'b000000001) begin
      fails++; $display("FAIL route_fu12: got %b expected 000000001", out_valid);
    end
    idle(9'h1FE);
    tests++;
    if (count !== 3'd2) begin
      fails++; $display("FAIL route_other_ready_ignored: got count %0d expected 2", count);
    end
    idle(9'h001);
    idle(9'h0);
    tests++;
    if (out_valid !== 9'b000000001) begin
      fails++; $display("FAIL route_sinvalid: got %b expected 000000001", out_valid);
    end
    idle(9'h1FF);
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 4; i++) drive(1'b1, mk(4'd3, 1'b0, 1'b1), 9'h0, 1'b0);
    drive(1'b1, mk(4'd2, 1'b0, 1'b1), 9'b000001000, 1'b0);
    tests++;
    if (in_ready !== 1'b0) begin
      fails++; $display("FAIL full_pushpop_ready: got %b expected 0", in_ready);
    end
    idle(9'h0);
    tests++;
    if (count !== 3'd3) begin
      fails++; $display("FAIL full_pushpop_count: got %0d expected 3", count);
    end
    drive(1'b1, mk(4'd8, 1'b0, 1'b1), 9'h0, 1'b0);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL full_next_push: got ready %b expected 1", in_ready);
    end
    idle(9'h0);
    tests++;
    if (count !== 3'd4) begin
      fails++; $display("FAIL full_refill: got %0d expected 4", count);
    end
    repeat (5) idle(9'h1FF);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) drive(1'b1, mk(4'd7, 1'b0, 1'b1), 9'h0, 1'b0);
    drive(1'b1, mk(4'd7, 1'b0, 1'b1), 9'h1FF, 1'b1);
    tests++;
    if (out_valid !== 9'b0 || in_ready !== 1'b0) begin
      fails++; $display("FAIL flush_same_cycle: valid=%b ready=%b expected 0/0", out_valid, in_ready);
    end
    idle(9'h0);
    tests++;
    if (count !== 3'd0 || stall !== 16'd0) begin
      fails++; $display("FAIL flush_next: count=%0d stall=%0d expected 0/0", count, stall);
    end
  endtask

  task automatic test_bypass();
    C::di_t m;
    m = mk(4'd4, 1'b0, 1'b1);
    drive(1'b1, m, 9'b000010000, 1'b0);
    tests++;
    if (BYP ? (out_valid !== 9'b000010000 || out_di !== m) : (out_valid !== 9'b0)) begin
      fails++; $display("FAIL bypass_same_cycle: got %b", out_valid);
    end
    idle(9'b000010000);
    tests++;
    if (BYP ? (count !== 3'd0) : (out_valid !== 9'b000010000 || count !== 3'd1)) begin
      fails++; $display("FAIL bypass_next: valid=%b count=%0d", out_valid, count);
    end
    idle(9'h1FF);
  endtask

  task automatic test_back_to_back();
    drive(1'b1, mk(4'd3, 1'b0, 1'b1), 9'b000001000, 1'b0);
    for (int i = 1; i < 8; i++) begin
      drive(1'b1, mk(4'd3, 1'b0, 1'b1), 9'b000001000, 1'b0);
      tests++;
      if (count !== (BYP ? 3'd0 : 3'd1)) begin
        fails++; $display("FAIL throughput_%0d: got count %0d", i, count);
      end
    end
    repeat (2) idle(9'h1FF);
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(3) != 0),
            mk(4'($urandom_range(15)), ($urandom_range(7) == 0), ($urandom_range(7) != 0)),
            9'($urandom), ($urandom_range(39) == 0));
    end
    repeat (6) idle(9'h1FF);
  endtask

  task automatic test_async_reset();
    drive(1'b1, mk(4'd1, 1'b0, 1'b1), 9'h0, 1'b0);
    drive(1'b1, mk(4'd1, 1'b0, 1'b1), 9'h0, 1'b0);
    idle(9'h0);
    rst_n = 1'b0;
    #1;
    tests++;
    if (count !== 3'd0 || out_valid !== 9'd0 || in_ready !== 1'b1 || out_di !== C::di_t'('0)) begin
      fails++;
      $display("FAIL async_reset: count=%0d valid=%b ready=%b expected 0/0/1", count, out_valid, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(9'h0);
    tests++;
    if (count !== 3'd0) begin
      fails++; $display("FAIL async_reset_after: got %0d expected 0", count);
    end
  endtask

  initial begin
    test_reset();
    test_basic_alu();
    test_fill_stall();
    test_routing_fault();
    test_full_push_pop();
    test_flush();
    test_bypass();
    test_back_to_back();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
